// File: rtl/lut_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : lut_cfg_loader
// Description : Serial loader for the configurable-cell truth tables. Takes a
//               framed MSB-first bit stream, checks even parity, and commits
//               all 4-bit tables to lut_cfg in a single edge.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_cfg_loader #(
  parameter int N_CELLS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  output logic                   cfg_ready,
  output logic                   busy,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic [4*N_CELLS-1:0]   lut_cfg
);

  localparam int CFG_BITS = 4 * N_CELLS;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CFG_BITS-1:0] r_shadow;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ready;
  logic                r_done;
  logic                r_err;
  logic [CFG_BITS-1:0] r_lut;

  logic w_xfer;
  logic w_restart;
  logic w_last_data;
  logic w_par_ok;
  logic w_par_err;

  // Handshake and frame-control qualifiers; a start during COMMIT is dropped
  always_comb begin
    w_xfer      = cfg_valid && r_ready;
    w_restart   = cfg_start && (r_state != S_COMMIT);
    w_last_data = (r_cnt == CNT_W'(CFG_BITS - 1));
    w_par_ok    = (cfg_bit == (^r_shadow));
    w_par_err   = (r_state == S_PARITY) && !cfg_start && w_xfer && !w_par_ok;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a start outside COMMIT always restarts the frame
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (cfg_start)                 w_next = S_SHIFT;
        else if (w_xfer && w_last_data) w_next = S_PARITY;
      end
      S_PARITY: begin
        if (cfg_start)   w_next = S_SHIFT;
        else if (w_xfer) w_next = w_par_ok ? S_COMMIT : S_IDLE;
      end
      S_COMMIT: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: shadow shift, bit count, flags and the atomic table commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_lut    <= {N_CELLS{4'b1000}};
    end else begin
      // ready is registered from the next state so it never depends on cfg_valid
      r_ready <= (w_next == S_SHIFT) || (w_next == S_PARITY);
      r_done  <= (r_state == S_COMMIT);

      if (w_restart) begin
        r_shadow <= '0;
        r_cnt    <= '0;
        r_err    <= 1'b0;
      end else if ((r_state == S_SHIFT) && w_xfer) begin
        r_shadow <= {r_shadow[CFG_BITS-2:0], cfg_bit};
        r_cnt    <= r_cnt + CNT_W'(1);
      end

      if (w_par_err) begin
        r_err <= 1'b1;
      end

      if (r_state == S_COMMIT) begin
        r_lut <= r_shadow;
      end
    end
  end

  assign cfg_ready = r_ready;
  assign busy      = (r_state != S_IDLE);
  assign cfg_done  = r_done;
  assign cfg_err   = r_err;
  assign lut_cfg   = r_lut;

endmodule
`default_nettype wire

// File: tb/tb_lut_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_cfg_loader
// Description : Randomised self-checking bench for lut_cfg_loader, with a
//               frame-level reference model of the committed truth tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_cfg_loader;

  localparam int N_CELLS  = 4;
  localparam int CFG_BITS = 4 * N_CELLS;
  localparam logic [15:0] c_DEFAULT = 16'h8888;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic        cfg_valid;
  logic        cfg_bit;
  logic        cfg_ready;
  logic        busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [15:0] lut_cfg;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [15:0] exp_lut;

  lut_cfg_loader #(.N_CELLS(N_CELLS)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .lut_cfg   (lut_cfg)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between clock edges and check outputs before any edge
  task automatic async_reset();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("rst_lut",   32'(lut_cfg),   32'(c_DEFAULT));
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(cfg_done),  32'd0);
    chk("rst_err",   32'(cfg_err),   32'd0);
    exp_lut = c_DEFAULT;
    #2;
    rst = 1'b0;
    step();
  endtask

  // Start pulse; v chooses whether a (to-be-discarded) valid bit rides along
  task automatic do_start(input logic v);
    cfg_start = 1'b1;
    cfg_valid = v;
    cfg_bit   = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    chk("start_busy",  32'(busy),      32'd1);
    chk("start_ready", 32'(cfg_ready), 32'd1);
    chk("start_err",   32'(cfg_err),   32'd0);
    chk("start_done",  32'(cfg_done),  32'd0);
    chk("start_lut",   32'(lut_cfg),   32'(exp_lut));
  endtask

  // Stream the first nbits of seq (MSB first) with random stalls
  task automatic send_bits(input logic [16:0] seq, input int nbits, input int stall_pct,
                           output int nx, output int edges);
    logic rdy;
    nx    = 0;
    edges = 0;
    while (nx < nbits && edges < 400) begin
      cfg_valid = ($urandom_range(99) >= 32'(stall_pct));
      cfg_bit   = cfg_valid ? seq[16-nx] : 1'($urandom);
      rdy       = cfg_ready;
      chk("in_frame_ready", 32'(cfg_ready), 32'd1);
      chk("in_frame_busy",  32'(busy),      32'd1);
      step();
      edges++;
      if (cfg_valid && rdy) nx++;
      chk("lut_hold", 32'(lut_cfg), 32'(exp_lut));
    end
    cfg_valid = 1'b0;
    if (nx < nbits) chk("timeout_bits", 32'(nx), 32'(nbits));
  endtask

  // One complete frame; expected outcome follows from even parity over data+parity
  task automatic frame(input logic [15:0] d, input logic p, input int stall_pct,
                       input logic start_v, input logic start_in_commit);
    int   nx;
    int   edges;
    logic good;
    do_start(start_v);
    send_bits({d, p}, 17, stall_pct, nx, edges);
    chk("xfers", 32'(nx), 32'(CFG_BITS + 1));
    if (stall_pct == 0) chk("parity_edge", 32'(edges), 32'(CFG_BITS + 1));
    good = (p == (^d));
    if (good) begin
      chk("commit_busy",  32'(busy),      32'd1);
      chk("commit_ready", 32'(cfg_ready), 32'd0);
      chk("commit_done",  32'(cfg_done),  32'd0);
      chk("commit_err",   32'(cfg_err),   32'd0);
      chk("commit_lut",   32'(lut_cfg),   32'(exp_lut));
      cfg_start = start_in_commit;
      step();
      cfg_start = 1'b0;
      exp_lut = d;
      chk("done_pulse", 32'(cfg_done),  32'd1);
      chk("done_lut",   32'(lut_cfg),   32'(exp_lut));
      chk("done_busy",  32'(busy),      32'd0);
      chk("done_ready", 32'(cfg_ready), 32'd0);
      step();
      chk("done_fall",  32'(cfg_done),  32'd0);
      chk("idle_busy",  32'(busy),      32'd0);
      chk("idle_lut",   32'(lut_cfg),   32'(exp_lut));
    end else begin
      chk("perr_err",   32'(cfg_err),   32'd1);
      chk("perr_busy",  32'(busy),      32'd0);
      chk("perr_ready", 32'(cfg_ready), 32'd0);
      chk("perr_done",  32'(cfg_done),  32'd0);
      chk("perr_lut",   32'(lut_cfg),   32'(exp_lut));
      step();
      chk("perr_nodone", 32'(cfg_done), 32'd0);
      chk("perr_sticky", 32'(cfg_err),  32'd1);
      chk("perr_lut2",   32'(lut_cfg),  32'(exp_lut));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nx;
    int          edges;
    logic [15:0] d;
    logic        p;

    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    exp_lut   = c_DEFAULT;
    #12;
    chk("init_lut",   32'(lut_cfg),   32'(c_DEFAULT));
    chk("init_ready", 32'(cfg_ready), 32'd0);
    chk("init_busy",  32'(busy),      32'd0);
    chk("init_done",  32'(cfg_done),  32'd0);
    chk("init_err",   32'(cfg_err),   32'd0);
    rst = 1'b0;
    step();

    // Valid in IDLE must be ignored
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    step();
    step();
    cfg_valid = 1'b0;
    chk("idle_ignore_busy", 32'(busy),    32'd0);
    chk("idle_ignore_lut",  32'(lut_cfg), 32'(c_DEFAULT));

    // Good frame, then asynchronous reset back to all-AND
    frame(16'hE8E8, 1'b0, 0, 1'b1, 1'b0);
    async_reset();

    // Parity error: table untouched, error sticky until the next start
    frame(16'hE8E8, 1'b1, 0, 1'b0, 1'b0);

    // Stalled stream
    frame(16'h1E1E, 1'b0, 50, 1'b0, 1'b0);

    // Abort after 9 ones; the bit presented with the start is discarded
    do_start(1'b0);
    send_bits({16'hFFFF, 1'b0}, 9, 0, nx, edges);
    frame(16'h8E8E, 1'b0, 0, 1'b1, 1'b0);

    // Start during COMMIT is ignored
    frame(16'(($urandom)), 1'b0, 0, 1'b0, 1'b1);
    // Re-run with matching parity so the commit path is exercised for sure
    d = 16'h3C5A;
    frame(d, ^d, 0, 1'b0, 1'b1);

    // Reset after 5 bits of a frame
    do_start(1'b0);
    send_bits({16'(($urandom)), 1'b0}, 5, 0, nx, edges);
    async_reset();

    // Randomised frames with occasional aborts and resets
    for (int i = 0; i < 24; i++) begin
      d = 16'($urandom);
      p = (^d) ^ ($urandom_range(3) == 0);
      if ($urandom_range(4) == 0) begin
        do_start(1'b0);
        send_bits({16'($urandom), 1'($urandom)}, int'($urandom_range(1, 16)), 0, nx, edges);
      end
      frame(d, p, ($urandom_range(1) == 1) ? 50 : 0, 1'($urandom), 1'($urandom));
      if ($urandom_range(7) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lut_cfg_loader.md
# lut_cfg_loader

Serial configuration loader for the bank of configurable logic cells. It receives a framed bit stream, checks even parity, and atomically commits a 4-bit truth table per cell. The committed truth tables drive the cells' function selects, replacing the hand-wired AND/OR select switch. It sits directly upstream of the configurable-gate stage, and `lut_cfg` feeds that stage combinationally.

## Interface
- `N_CELLS`, default 4: number of configurable 2-input cells. `CFG_BITS` = 4*N_CELLS (derived, not overridable).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_start`  in  1  one-cycle pulse that begins a new frame.
- `cfg_valid`  in  1  `cfg_bit` is valid this cycle.
- `cfg_bit`  in  1  serial data or parity bit.
- `cfg_ready`  out  1  loader accepts a bit this cycle. A bit transfers when `cfg_valid` && `cfg_ready`.
- `busy`  out  1  a frame is in progress (any state other than IDLE).
- `cfg_done`  out  1  one-cycle pulse on successful commit.
- `cfg_err`  out  1  sticky parity-error flag; cleared by `cfg_start` or `rst`.
- `lut_cfg`  out  CFG_BITS  committed truth tables.
  - Cell i occupies bits [4i+3:4i].
  - Bit k of a cell is the cell output for inputs {I1,I0}=k.
  - AND = 4'b1000, OR = 4'b1110.

## Operation
- **States:** IDLE, SHIFT, PARITY, COMMIT.
- **Reset values** (asynchronous, immediate): state IDLE, `cfg_ready`=0, `busy`=0, `cfg_done`=0, `cfg_err`=0. `lut_cfg` = every cell 4'b1000 (all AND), i.e. 16'h8888 for N_CELLS=4. Shadow register and bit counter are cleared to 0.
- **IDLE:**
  - `cfg_start` → SHIFT. Clear the counter, the shadow and `cfg_err`.
  - `cfg_valid` is ignored.
- **SHIFT:**
  - On each transfer, shadow <= {shadow[CFG_BITS-2:0], `cfg_bit`} and the counter increments.
  - After the CFG_BITS-th transfer → PARITY.
  - The first bit sent ends up at `lut_cfg` MSB (cell N_CELLS-1, bit 3).
- **PARITY:**
  - On transfer, compare `cfg_bit` with the XOR of all shadow bits (even parity over data plus parity bit).
  - Match → COMMIT.
  - Mismatch → set `cfg_err` and go to IDLE. `lut_cfg` is unchanged.
- **COMMIT:** on the next edge, `lut_cfg` <= shadow, `cfg_done` = 1 for exactly one cycle, state → IDLE.
- **Stalls:** cycles with `cfg_valid`=0 in SHIFT or PARITY leave all state unchanged; there is no timeout.
- **`cfg_start` during SHIFT or PARITY:** aborts the frame and restarts as from IDLE (counter and shadow cleared, `cfg_err` cleared). Any bit presented that same cycle is discarded. `lut_cfg` is untouched.
- **`cfg_start` during COMMIT:** ignored. The commit completes and the loader returns to IDLE; a new start is required.
- **`rst` mid-frame:** the loader returns to IDLE, and `lut_cfg` reverts to the all-AND default, not to the last committed value.
- **Output stability:** `lut_cfg` changes only on a COMMIT edge or on reset. Partial frames are never visible at the output.

## Timing
- `cfg_ready` is 1 exactly in SHIFT and PARITY. It is registered, with no combinational path from `cfg_valid`.
- `busy` is 1 in SHIFT, PARITY and COMMIT.
- A frame is CFG_BITS+1 transfers. With `cfg_valid` held high, `cfg_start` is applied at edge 0:
  - `cfg_ready` rises after edge 0.
  - Data bits are accepted at edges 1..CFG_BITS.
  - The parity bit is accepted at edge CFG_BITS+1.
  - `lut_cfg` updates and `cfg_done` rises at edge CFG_BITS+2.
  - `cfg_done` falls at edge CFG_BITS+3.
- A parity error is visible on `cfg_err` after the parity edge (CFG_BITS+1). No `cfg_done` pulse is produced.
- Back-to-back frames: `cfg_start` may be asserted in the cycle `cfg_done` is high, since the state is IDLE then.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `lut_cfg`=16'h8888, `cfg_ready`=0, `busy`=0, `cfg_done`=0 and `cfg_err`=0 immediately, with no clock edge needed.
- **Good frame** (N_CELLS=4): start, then data 16'hE8E8 MSB-first, then parity 0 → `cfg_done` pulses once at edge 18, `lut_cfg`=16'hE8E8, `cfg_err`=0.
- **Parity error:** same data with parity bit 1 → `cfg_err`=1 after edge 17, no `cfg_done`, `lut_cfg` remains 16'h8888. A following `cfg_start` clears `cfg_err`.
- **Stalled stream:** frame 16'h1E1E with parity 0, and `cfg_valid` low on a random 50% of cycles → same result as the unstalled frame, with exactly 17 transfers counted.
- **Abort:** 9 bits of 16'hFFFF, then `cfg_start` with `cfg_valid`=1 → that bit is discarded. A full frame 16'h8E8E with parity 0 then commits 16'h8E8E, and `lut_cfg` never shows any F nibble.
- **Start in COMMIT, and reset mid-frame:**
  - `cfg_start` during COMMIT is ignored: the loader goes to IDLE and `busy`=0 on the next cycle.
  - `rst` after 5 bits of a second frame → `lut_cfg` returns to 16'h8888.
